// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    LOAD,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  // Quarter indices within one SCL period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // R/W bit appended to the 7-bit address
  localparam logic WRITE = 1'b0;

  localparam int ADDR_BITS = 8;

  // Bit counter must also cover the 8-bit address byte
  function automatic int bit_cnt_width(input int data_size);
    return (data_size > ADDR_BITS) ? $clog2(data_size) : 3;
  endfunction

endpackage

// File: rtl/i2c_write_engine_if.sv
// Host/FIFO/bus signal bundle of the I2C write engine.
// master: the engine itself (it is the I2C bus master).
// slave:  everything around it (host, TX FIFO read port, SDA line).
interface i2c_write_engine_if #(
  parameter int DATA_SIZE = 8
);
  logic                 start;
  logic [6:0]           slave_address;
  logic [DATA_SIZE-1:0] fifo_read_data;
  logic                 fifo_read_empty;
  logic                 fifo_read_enable;
  logic                 sda_in;
  logic                 scl_out;
  logic                 sda_out;
  logic                 busy;
  logic                 done;
  logic                 nack_error;

  modport master (
    input  start, slave_address, fifo_read_data, fifo_read_empty, sda_in,
    output fifo_read_enable, scl_out, sda_out, busy, done, nack_error
  );

  modport slave (
    output start, slave_address, fifo_read_data, fifo_read_empty, sda_in,
    input  fifo_read_enable, scl_out, sda_out, busy, done, nack_error
  );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Prescaler: one-cycle tick every CLK_DIV enabled clocks, held at 0 when cleared.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc   = (r_cnt == LAST);
  assign o_tick = i_en && !i_clr && w_tc;

  // Count enabled cycles, wrapping at the terminal count
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_tc) r_cnt <= '0;
      else      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_write_engine.sv
// I2C write-only master: START, address+W, data bytes popped from a TX FIFO, STOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus released, waiting for start
// START    | 4 quarters: SDA falls at q2 with SCL high, SCL falls at q3
// ADDR     | shift out {slave_address, W}, MSB first, 4 quarters per bit
// ADDR_ACK | SDA released, sample sda_in at end of q2
// LOAD     | one cycle: pop FIFO head into shifter, or STOP if empty
// DATA     | shift out data byte, MSB first
// DATA_ACK | SDA released, sample sda_in at end of q2
// STOP     | SDA low, SCL rises at q1, SDA released at q3, then done
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                   read_clk,
  input  logic                   read_reset,
  i2c_write_engine_if.master     bus
);

  localparam int BIT_W = bit_cnt_width(DATA_SIZE);

  state_t               r_state;
  logic [1:0]           r_qtr;
  logic [BIT_W-1:0]     r_bit;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_ack_bit;
  logic                 r_scl;
  logic                 r_sda;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_nack;
  logic                 r_fifo_re;

  logic                 w_tick;
  logic                 w_tick_clr;
  logic [BIT_W-1:0]     w_last_bit;

  assign w_tick_clr = !r_busy;
  assign w_last_bit = (r_state == DATA) ? BIT_W'(DATA_SIZE - 1) : BIT_W'(ADDR_BITS - 1);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_quarter_tick (
    .i_clk  (read_clk),
    .i_rst  (read_reset),
    .i_en   (r_busy),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  // Sequencer: every tick ends the current quarter and sets the lines for the next one
  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      r_state   <= IDLE;
      r_qtr     <= Q0;
      r_bit     <= '0;
      r_addr    <= '0;
      r_shift   <= '0;
      r_ack_bit <= 1'b0;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
      r_fifo_re <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_fifo_re <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_addr  <= {bus.slave_address, WRITE};
            r_busy  <= 1'b1;
            r_nack  <= 1'b0;
            r_qtr   <= Q0;
            r_bit   <= '0;
            r_state <= START;
          end
        end

        START: begin
          if (w_tick) begin
            r_qtr <= r_qtr + 2'd1;
            case (r_qtr)
              Q1: r_sda <= 1'b0;
              Q2: r_scl <= 1'b0;
              Q3: begin
                r_sda   <= r_addr[ADDR_BITS-1];
                r_state <= ADDR;
              end
              default: ;
            endcase
          end
        end

        ADDR, DATA: begin
          if (w_tick) begin
            r_qtr <= r_qtr + 2'd1;
            case (r_qtr)
              Q1: r_scl <= 1'b1;
              Q3: begin
                r_scl <= 1'b0;
                if (r_bit == w_last_bit) begin
                  r_bit   <= '0;
                  r_sda   <= 1'b1;
                  r_state <= (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
                end else begin
                  r_bit <= r_bit + 1'b1;
                  if (r_state == ADDR) begin
                    r_addr <= r_addr << 1;
                    r_sda  <= r_addr[ADDR_BITS-2];
                  end else begin
                    r_shift <= r_shift << 1;
                    r_sda   <= r_shift[DATA_SIZE-2];
                  end
                end
              end
              default: ;
            endcase
          end
        end

        ADDR_ACK, DATA_ACK: begin
          if (w_tick) begin
            r_qtr <= r_qtr + 2'd1;
            case (r_qtr)
              Q1: r_scl     <= 1'b1;
              Q2: r_ack_bit <= bus.sda_in;
              Q3: begin
                r_scl <= 1'b0;
                if (r_ack_bit) begin
                  r_nack  <= 1'b1;
                  r_sda   <= 1'b0;
                  r_state <= STOP;
                end else begin
                  r_state <= LOAD;
                end
              end
              default: ;
            endcase
          end
        end

        // Occupies the first cycle of the next q0; CLK_DIV >= 2 keeps a tick out of it
        LOAD: begin
          if (bus.fifo_read_empty) begin
            r_sda   <= 1'b0;
            r_state <= STOP;
          end else begin
            r_shift   <= bus.fifo_read_data;
            r_sda     <= bus.fifo_read_data[DATA_SIZE-1];
            r_fifo_re <= 1'b1;
            r_state   <= DATA;
          end
        end

        STOP: begin
          if (w_tick) begin
            r_qtr <= r_qtr + 2'd1;
            case (r_qtr)
              Q0: r_scl <= 1'b1;
              Q2: r_sda <= 1'b1;
              Q3: begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
              default: ;
            endcase
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.scl_out          = r_scl;
  assign bus.sda_out          = r_sda;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.nack_error       = r_nack;
  assign bus.fifo_read_enable = r_fifo_re;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench: I2C slave/FIFO model that decodes the SCL/SDA waveform and checks whole transactions.
module tb_i2c_write_engine;

  logic read_clk   = 1'b0;
  logic read_reset = 1'b1;

  always #5 read_clk = ~read_clk;

  i2c_write_engine_if #(.DATA_SIZE(8)) bus ();

  i2c_write_engine #(
    .DATA_SIZE (8),
    .CLK_DIV   (2)
  ) dut (
    .read_clk   (read_clk),
    .read_reset (read_reset),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] plan[$];
  logic [7:0] sent[$];
  int pops, dones, starts, stops, nbits, nack_at;
  logic [7:0] cur = 8'h00;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, act as FIFO and I2C slave
  task automatic tick();
    logic scl, sda;
    logic [7:0] junk;
    @(negedge read_clk);
    if (bus.fifo_read_enable) begin
      pops++;
      if (fifo_q.size() > 0) junk = fifo_q.pop_front();
    end
    if (bus.done) dones++;
    scl = bus.scl_out;
    sda = bus.sda_out;
    if (scl && p_scl && p_sda && !sda) begin
      starts++;
      nbits = 0;
    end else if (scl && p_scl && !p_sda && sda) begin
      stops++;
      nbits = 0;
    end else if (scl && !p_scl) begin
      if (nbits < 8) begin
        cur = {cur[6:0], sda};
        nbits++;
      end else begin
        sent.push_back(cur);
        nbits = 0;
      end
    end else if (!scl && p_scl) begin
      if (nbits == 8) bus.sda_in = (sent.size() == nack_at) ? 1'b1 : 1'b0;
      else            bus.sda_in = 1'b1;
    end
    p_scl = scl;
    p_sda = sda;
    bus.fifo_read_empty = (fifo_q.size() == 0);
    bus.fifo_read_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic clear_mon();
    sent.delete();
    pops = 0; dones = 0; starts = 0; stops = 0; nbits = 0;
  endtask

  // Run one write; nk = index of the byte to NACK (0 = address), 99 = never
  task automatic run_tx(input logic [6:0] addr, input int nk, input bit late, input bit dbl,
                        input string name);
    int len, exp_pops;
    bit exp_nack, timed_out;
    clear_mon();
    nack_at = nk;
    len = plan.size();
    if (!late) foreach (plan[i]) fifo_q.push_back(plan[i]);
    tick();
    bus.slave_address = addr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.slave_address = 7'($urandom);
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (late && c == 8) foreach (plan[i]) fifo_q.push_back(plan[i]);
      if (dbl && c == 30) begin
        bus.start = 1'b1;
        bus.slave_address = addr ^ 7'h55;
      end else if (dbl && c == 31) begin
        bus.start = 1'b0;
      end
      tick();
      if (dones > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) tick();

    exp_pops = (nk < len) ? nk : len;
    exp_nack = (nk <= len);
    check_eq({name, "_timeout"}, 32'(timed_out), 0);
    check_eq({name, "_nbytes"}, sent.size(), 1 + exp_pops);
    if (sent.size() > 0) check_eq({name, "_addr"}, 32'(sent[0]), 32'({addr, 1'b0}));
    for (int i = 1; i < sent.size() && i <= exp_pops; i++)
      check_eq({name, "_data"}, 32'(sent[i]), 32'(plan[i-1]));
    check_eq({name, "_pops"}, pops, exp_pops);
    check_eq({name, "_nack"}, 32'(bus.nack_error), 32'(exp_nack));
    check_eq({name, "_done"}, dones, 1);
    check_eq({name, "_starts"}, starts, 1);
    check_eq({name, "_stops"}, stops, 1);
    check_eq({name, "_busy"}, 32'(bus.busy), 0);
    check_eq({name, "_left"}, fifo_q.size(), len - exp_pops);
    fifo_q.delete();
    tick();
  endtask

  initial begin
    int len, r, nk;
    bit timed_out;
    bus.start = 1'b0;
    bus.slave_address = 7'h00;
    bus.sda_in = 1'b1;
    bus.fifo_read_empty = 1'b1;
    bus.fifo_read_data = 8'h00;
    clear_mon();
    nack_at = 99;

    repeat (3) tick();
    check_eq("rst_scl", 32'(bus.scl_out), 1);
    check_eq("rst_sda", 32'(bus.sda_out), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_nack", 32'(bus.nack_error), 0);
    check_eq("rst_pop", 32'(bus.fifo_read_enable), 0);
    read_reset = 1'b0;
    tick();

    plan = '{8'hA5, 8'h3C};
    run_tx(7'h50, 99, 1'b0, 1'b0, "basic");
    plan = '{8'h11};
    run_tx(7'h21, 0, 1'b0, 1'b0, "addr_nack");
    plan = '{8'h81, 8'h42, 8'h7E};
    run_tx(7'h33, 2, 1'b0, 1'b0, "data_nack");
    plan.delete();
    run_tx(7'h50, 99, 1'b0, 1'b0, "probe");
    plan = '{8'hC3, 8'h5A};
    run_tx(7'h15, 99, 1'b0, 1'b1, "busy_start");
    plan = '{8'h96, 8'h01};
    run_tx(7'h7F, 99, 1'b1, 1'b0, "late_push");

    for (int t = 0; t < 8; t++) begin
      plan.delete();
      len = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) plan.push_back(8'($urandom));
      r  = $urandom_range(0, 3);
      nk = (r == 0) ? $urandom_range(0, len) : 99;
      run_tx(7'($urandom), nk, 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    // Reset during bit 4 of the first data byte
    plan = '{8'hF0, 8'h0F, 8'hAA};
    clear_mon();
    nack_at = 99;
    foreach (plan[i]) fifo_q.push_back(plan[i]);
    tick();
    bus.slave_address = 7'h2A;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (sent.size() == 1 && nbits == 4 && !bus.scl_out) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_eq("rst_mid_timeout", 32'(timed_out), 0);
    check_eq("rst_mid_pops_before", pops, 1);
    read_reset = 1'b1;
    tick();
    check_eq("rst_mid_scl", 32'(bus.scl_out), 1);
    check_eq("rst_mid_sda", 32'(bus.sda_out), 1);
    check_eq("rst_mid_busy", 32'(bus.busy), 0);
    check_eq("rst_mid_pop", 32'(bus.fifo_read_enable), 0);
    read_reset = 1'b0;
    repeat (20) tick();
    check_eq("rst_mid_pops_after", pops, 1);
    check_eq("rst_mid_idle", 32'(bus.busy), 0);
    check_eq("rst_mid_left", fifo_q.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
